// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Step counter width for a given operand width.
  function automatic int count_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational N-bit ripple-carry adder.
module adder_nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  logic [N:0] carry_s;

  // Ripple the carry from bit 0 upward.
  always_comb begin
    carry_s    = {(N+1){1'b0}};
    sum_o      = {N{1'b0}};
    carry_s[0] = carry_i;
    for (int i = 0; i < N; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry_s[i];
      carry_s[i+1] = (a_i[i] & b_i[i]) | (a_i[i] & carry_s[i]) | (b_i[i] & carry_s[i]);
    end
    carry_o = carry_s[N];
  end

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier with valid/ready handshakes.
// Build option: MULT_EARLY_EXIT_EN stops RUN once the remaining multiplier bits are zero.
module mult_shift_add
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [2*WIDTH-1:0] product_o,
  output logic               busy_o
);

  localparam int PW      = 2 * WIDTH;
  localparam int COUNT_W = count_width(WIDTH);

  state_e             state_r;
  logic [PW-1:0]      acc_r;
  logic [PW-1:0]      mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [COUNT_W-1:0] count_r;
  logic [PW-1:0]      product_r;
  logic               req_ready_r;
  logic               resp_valid_r;
  logic               busy_r;

  logic [PW-1:0]      sum_s;
  logic               carry_unused;
  logic [PW-1:0]      next_acc_s;
  logic               last_step_s;

  adder_nbit #(
    .N (PW)
  ) u_adder (
    .a_i     (acc_r),
    .b_i     (mcand_r),
    .carry_i (1'b0),
    .sum_o   (sum_s),
    .carry_o (carry_unused)
  );

  // Partial-product selection and end-of-run detection for the current step.
  always_comb begin
    next_acc_s  = acc_r;
    last_step_s = 1'b0;
    if (mplier_r[0]) begin
      next_acc_s = sum_s;
    end else begin
      next_acc_s = acc_r;
    end
`ifdef MULT_EARLY_EXIT_EN
    last_step_s = (count_r == COUNT_W'(WIDTH - 1)) || ((mplier_r >> 1) == {WIDTH{1'b0}});
`else
    last_step_s = (count_r == COUNT_W'(WIDTH - 1));
`endif
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= IDLE;
      acc_r        <= {PW{1'b0}};
      mcand_r      <= {PW{1'b0}};
      mplier_r     <= {WIDTH{1'b0}};
      count_r      <= {COUNT_W{1'b0}};
      product_r    <= {PW{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid_i && req_ready_r) begin
            acc_r       <= {PW{1'b0}};
            mcand_r     <= {{WIDTH{1'b0}}, a_i};
            mplier_r    <= b_i;
            count_r     <= {COUNT_W{1'b0}};
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= RUN;
          end else begin
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        RUN: begin
          acc_r    <= next_acc_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + COUNT_W'(1);
          if (last_step_s) begin
            product_r    <= next_acc_s;
            resp_valid_r <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= DONE;
          end else begin
            busy_r <= 1'b1;
          end
        end
        DONE: begin
          // Returning to IDLE raises ready; acceptance waits for the next edge.
          if (resp_ready_i) begin
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_r;
  assign resp_valid_o = resp_valid_r;
  assign product_o    = product_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_mult_shift_add.sv
// Directed self-checking bench for mult_shift_add; latency model follows MULT_EARLY_EXIT_EN.
module tb_mult_shift_add;

  localparam int W = 16;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           req_valid_i;
  logic           req_ready_o;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           resp_valid_o;
  logic           resp_ready_i;
  logic [2*W-1:0] product_o;
  logic           busy_o;

  int checks = 0;
  int errors = 0;

  mult_shift_add #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .product_o    (product_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
    int hb = -1;
    for (int i = 0; i < W; i++) if (b[i]) hb = i;
    return (hb < 0) ? 1 : hb + 1;
`else
    return W;
`endif
  endfunction

  // Accept one request, wait for the response, check product and latency.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input bit release_resp);
    int n;
    n = 0;
    a_i = a;
    b_i = b;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    a_i = W'($urandom);
    b_i = W'($urandom);
    while (n < 40) begin
      @(posedge clk_i);
      n++;
      #1;
      if (n == 1) begin
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        check({tag, "_ready_low"}, 64'(req_ready_o), 64'd0);
      end
      if (resp_valid_o) break;
    end
    check({tag, "_product"}, 64'(product_o), 64'(exp_p));
    check({tag, "_latency"}, 64'(n), 64'(exp_latency(b)));
    if (release_resp) begin
      resp_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      resp_ready_i = 1'b0;
      check({tag, "_resp_drop"}, 64'(resp_valid_o), 64'd0);
      check({tag, "_ready_rise"}, 64'(req_ready_o), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    repeat (5) @(posedge clk_i);
    #1;
    check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("rst_product", 64'(product_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("idle_req_ready", 64'(req_ready_o), 64'd1);
    check("idle_resp_valid", 64'(resp_valid_o), 64'd0);

    run_op("nominal", 16'd52215, 16'd39218, 32'd2047767870, 1'b1);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    run_op("a_zero", 16'h0000, 16'h1234, 32'd0, 1'b1);
    run_op("b_zero", 16'h1234, 16'h0000, 32'd0, 1'b1);
    run_op("b_three", 16'd1000, 16'd3, 32'd3000, 1'b1);
    run_op("b_msb", 16'd1, 16'h8000, 32'd32768, 1'b1);

    // Backpressure: hold the result for 10 cycles.
    run_op("bp", 16'd7, 16'd9, 32'd63, 1'b0);
    repeat (10) begin
      @(posedge clk_i);
      #1;
      check("bp_product", 64'(product_o), 64'd63);
      check("bp_resp_valid", 64'(resp_valid_o), 64'd1);
      check("bp_req_ready", 64'(req_ready_o), 64'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
    check("bp_release_idle", 64'(req_ready_o), 64'd1);
    check("bp_release_valid", 64'(resp_valid_o), 64'd0);

    // Reset during RUN cycle 7 discards the operation.
    a_i = 16'd100;
    b_i = 16'd200;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready_o), 64'd1);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
    check("midrst_product", 64'(product_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk_i);
      #1;
      if (resp_valid_o) seen = 1'b1;
    end
    check("midrst_no_resp", 64'(seen), 64'd0);
    run_op("after_rst", 16'd3, 16'd5, 32'd15, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
